// File: rtl/fetch_queue_if.sv
// Handshake bundle for fetch_queue: instruction-memory port, redirect and consumer side.
// The fetch queue connects through the slave modport; the driving environment uses master.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             imem_req;
    logic [31:0]      imem_addr;
    logic             imem_ack;
    logic [31:0]      imem_rdata;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             deq;
    logic             valid;
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic [CNT_W-1:0] count;

    modport slave (
        output imem_req, imem_addr, valid, instr, pc, count,
        input  imem_ack, imem_rdata, redirect, redirect_pc, deq
    );

    modport master (
        input  imem_req, imem_addr, valid, instr, pc, count,
        output imem_ack, imem_rdata, redirect, redirect_pc, deq
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch over req/ack into a {pc, instr} FIFO, flushed on redirect.
// Optional macro FQ_BYPASS_EN presents an acked word combinationally when the queue is empty.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.slave  fq
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, KILL} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_e           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      pend_pc_q, pend_pc_d;
    logic             imem_req_q, imem_req_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    entry_t           head_q, head_d;
    entry_t           mem_q [DEPTH];

    logic [31:0]      target_c;
    logic             push_c;
    logic             deq_c;
    logic             byp_take_c;
    logic             unused_pc_lsb;

    assign target_c      = {fq.redirect_pc[31:2], 2'b00};
    assign unused_pc_lsb = ^fq.redirect_pc[1:0];

`ifdef FQ_BYPASS_EN
    logic byp_c;
    assign byp_c      = (state_q == REQ) && fq.imem_ack && !fq.redirect && (count_q == '0);
    assign byp_take_c = byp_c && fq.deq;
`else
    assign byp_take_c = 1'b0;
`endif

    // Redirect outranks both push and dequeue; deq on an empty queue is dropped.
    assign push_c = (state_q == REQ) && fq.imem_ack && !fq.redirect && !byp_take_c;
    assign deq_c  = fq.deq && !fq.redirect && (count_q != '0);

    // FIFO occupancy, pointers and the registered head entry
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (fq.redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = CNT_W'(count_q + CNT_W'(push_c) - CNT_W'(deq_c));
            rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(deq_c));
            wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(push_c));
        end

        valid_d = (count_d != '0);
        head_d  = '{pc: 32'h0, instr: NOP};
        if (valid_d) begin
            // The incoming word lands directly at the new head when the queue drains to it.
            if (push_c && (wr_ptr_q == rd_ptr_d)) begin
                head_d = '{pc: fetch_pc_q, instr: fq.imem_rdata};
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Fetch control: one outstanding request at most, KILL waits out an orphaned request
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        case (state_q)
            IDLE: begin
                if (fq.redirect) begin
                    fetch_pc_d = target_c;
                end else if (count_d < CNT_W'(DEPTH)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (fq.imem_ack) begin
                    if (fq.redirect) begin
                        fetch_pc_d = target_c;
                        state_d    = IDLE;
                    end else begin
                        fetch_pc_d = 32'(fetch_pc_q + 32'd4);
                        state_d    = (count_d < CNT_W'(DEPTH)) ? REQ : IDLE;
                    end
                end else if (fq.redirect) begin
                    pend_pc_d = target_c;
                    state_d   = KILL;
                end
            end
            KILL: begin
                if (fq.imem_ack) begin
                    fetch_pc_d = fq.redirect ? target_c : pend_pc_q;
                    state_d    = IDLE;
                end else if (fq.redirect) begin
                    pend_pc_d = target_c;
                end
            end
            default: state_d = IDLE;
        endcase
        imem_req_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= RESET_PC;
            imem_req_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            head_q     <= '{pc: 32'h0, instr: NOP};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            imem_req_q <= imem_req_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
        end
    end

    // Storage array needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= '{pc: fetch_pc_q, instr: fq.imem_rdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(push_c && (count_q == CNT_W'(DEPTH)) && !deq_c))
                else $error("fetch_queue: push into a full queue");
        end
    end

    assign fq.imem_req  = imem_req_q;
    assign fq.imem_addr = fetch_pc_q;
    assign fq.count     = count_q;

`ifdef FQ_BYPASS_EN
    assign fq.valid = byp_c | valid_q;
    assign fq.instr = byp_c ? fq.imem_rdata : head_q.instr;
    assign fq.pc    = byp_c ? fetch_pc_q    : head_q.pc;
`else
    assign fq.valid = valid_q;
    assign fq.instr = head_q.instr;
    assign fq.pc    = head_q.pc;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill, streaming, redirect/KILL, flush, wrap and async reset.
// Memory model returns addr ^ 32'hDEAD_0000 for every fetch.
module tb_fetch_queue;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] SALT  = 32'hDEAD_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_queue_if #(.DEPTH(DEPTH)) fq_bus ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (fq_bus)
    );

    always #5 clk = ~clk;

    assign fq_bus.imem_rdata = fq_bus.imem_addr ^ SALT;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_req"},   32'(fq_bus.imem_req), 32'd0);
        check_eq({tag, "_addr"},  fq_bus.imem_addr,     32'h0);
        check_eq({tag, "_valid"}, 32'(fq_bus.valid),    32'd0);
        check_eq({tag, "_count"}, 32'(fq_bus.count),    32'd0);
        check_eq({tag, "_instr"}, fq_bus.instr,         NOP);
        check_eq({tag, "_pc"},    fq_bus.pc,            32'h0);
    endtask

    initial begin
        rst                = 1'b0;
        fq_bus.imem_ack    = 1'b0;
        fq_bus.deq         = 1'b0;
        fq_bus.redirect    = 1'b0;
        fq_bus.redirect_pc = 32'h0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst0");

        // Fill with ack tied high and no consumer
        rst             = 1'b1;
        fq_bus.imem_ack = 1'b1;
        tick();
        check_eq("fill_req", 32'(fq_bus.imem_req), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("fill_addr%0d", i), fq_bus.imem_addr, 32'(4 * i));
            tick();
        end
        check_eq("fill_count", 32'(fq_bus.count),    32'd4);
        check_eq("fill_req0",  32'(fq_bus.imem_req), 32'd0);
        check_eq("fill_valid", 32'(fq_bus.valid),    32'd1);
        check_eq("fill_pc",    fq_bus.pc,            32'h0);
        check_eq("fill_instr", fq_bus.instr,         32'hDEAD_0000);

        // Continuous dequeue: steady stream, count holds at 3
        fq_bus.deq = 1'b1;
        tick();
        check_eq("strm_count0", 32'(fq_bus.count),    32'd3);
        check_eq("strm_req",    32'(fq_bus.imem_req), 32'd1);
        check_eq("strm_addr",   fq_bus.imem_addr,     32'h10);
        for (int k = 0; k < 6; k++) begin
            check_eq($sformatf("strm_pc%0d", k),    fq_bus.pc,         32'(4 * (k + 1)));
            check_eq($sformatf("strm_instr%0d", k), fq_bus.instr,      32'(4 * (k + 1)) ^ SALT);
            check_eq($sformatf("strm_cnt%0d", k),   32'(fq_bus.count), 32'd3);
            tick();
        end
        fq_bus.deq      = 1'b0;
        fq_bus.imem_ack = 1'b0;

        // Redirect while a request at 0x8 is stalled
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        fq_bus.imem_ack = 1'b1;
        tick();
        tick();
        check_eq("kill_pre_addr",  fq_bus.imem_addr,     32'h8);
        check_eq("kill_pre_count", 32'(fq_bus.count),    32'd2);
        fq_bus.imem_ack    = 1'b0;
        fq_bus.redirect    = 1'b1;
        fq_bus.redirect_pc = 32'h100;
        tick();
        fq_bus.redirect = 1'b0;
        check_eq("kill_req",   32'(fq_bus.imem_req), 32'd1);
        check_eq("kill_addr",  fq_bus.imem_addr,     32'h8);
        check_eq("kill_count", 32'(fq_bus.count),    32'd0);
        check_eq("kill_valid", 32'(fq_bus.valid),    32'd0);
        tick();
        tick();
        check_eq("kill_hold_addr", fq_bus.imem_addr,     32'h8);
        check_eq("kill_hold_req",  32'(fq_bus.imem_req), 32'd1);
        fq_bus.imem_ack = 1'b1;
        tick();
        fq_bus.imem_ack = 1'b0;
        check_eq("kill_done_req",   32'(fq_bus.imem_req), 32'd0);
        check_eq("kill_done_addr",  fq_bus.imem_addr,     32'h100);
        check_eq("kill_done_count", 32'(fq_bus.count),    32'd0);
        tick();
        check_eq("tgt_req",  32'(fq_bus.imem_req), 32'd1);
        check_eq("tgt_addr", fq_bus.imem_addr,     32'h100);
        fq_bus.imem_ack = 1'b1;
        #1;
`ifdef FQ_BYPASS_EN
        check_eq("lat_byp_valid", 32'(fq_bus.valid), 32'd1);
        check_eq("lat_byp_pc",    fq_bus.pc,         32'h100);
`else
        check_eq("lat_valid0", 32'(fq_bus.valid), 32'd0);
`endif
        tick();
        check_eq("lat_valid1", 32'(fq_bus.valid),    32'd1);
        check_eq("lat_count",  32'(fq_bus.count),    32'd1);
        check_eq("lat_pc",     fq_bus.pc,            32'h100);
        check_eq("lat_instr",  fq_bus.instr,         32'h100 ^ SALT);

        // Redirect to unaligned target with ack and deq in the same cycle
        fq_bus.deq         = 1'b1;
        fq_bus.redirect    = 1'b1;
        fq_bus.redirect_pc = 32'h103;
        tick();
        fq_bus.redirect = 1'b0;
        fq_bus.deq      = 1'b0;
        fq_bus.imem_ack = 1'b0;
        check_eq("flush_count", 32'(fq_bus.count),    32'd0);
        check_eq("flush_valid", 32'(fq_bus.valid),    32'd0);
        check_eq("flush_instr", fq_bus.instr,         NOP);
        check_eq("flush_pc",    fq_bus.pc,            32'h0);
        check_eq("flush_req",   32'(fq_bus.imem_req), 32'd0);
        check_eq("flush_addr",  fq_bus.imem_addr,     32'h100);
        tick();
        check_eq("flush_nreq",  32'(fq_bus.imem_req), 32'd1);
        check_eq("flush_naddr", fq_bus.imem_addr,     32'h100);

        // Fill to DEPTH, then one dequeue reopens fetch
        fq_bus.imem_ack = 1'b1;
        repeat (4) tick();
        check_eq("full_count", 32'(fq_bus.count),    32'd4);
        check_eq("full_req",   32'(fq_bus.imem_req), 32'd0);
        check_eq("full_addr",  fq_bus.imem_addr,     32'h110);
        fq_bus.imem_ack = 1'b0;
        fq_bus.deq      = 1'b1;
        tick();
        fq_bus.deq = 1'b0;
        check_eq("reopen_req",   32'(fq_bus.imem_req), 32'd1);
        check_eq("reopen_addr",  fq_bus.imem_addr,     32'h110);
        check_eq("reopen_count", 32'(fq_bus.count),    32'd3);
        check_eq("reopen_pc",    fq_bus.pc,            32'h104);

        // Fetch address wraps past 0xFFFF_FFFC
        fq_bus.imem_ack    = 1'b1;
        fq_bus.redirect    = 1'b1;
        fq_bus.redirect_pc = 32'hFFFF_FFFC;
        tick();
        fq_bus.redirect = 1'b0;
        check_eq("wrap_idle_addr", fq_bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap_req_addr", fq_bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap_addr0", fq_bus.imem_addr, 32'h0);
        check_eq("wrap_pc",    fq_bus.pc,        32'hFFFF_FFFC);
        tick();
        fq_bus.imem_ack = 1'b0;
        check_eq("wrap_addr4", fq_bus.imem_addr,  32'h4);
        check_eq("wrap_count", 32'(fq_bus.count), 32'd2);

        // Asynchronous reset asserted while in KILL
        fq_bus.redirect    = 1'b1;
        fq_bus.redirect_pc = 32'h200;
        tick();
        fq_bus.redirect = 1'b0;
        check_eq("rk_req",   32'(fq_bus.imem_req), 32'd1);
        check_eq("rk_addr",  fq_bus.imem_addr,     32'h4);
        check_eq("rk_count", 32'(fq_bus.count),    32'd0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("rst_kill");
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_eq("rel_req",  32'(fq_bus.imem_req), 32'd1);
        check_eq("rel_addr", fq_bus.imem_addr,     32'h0);

`ifdef FQ_BYPASS_EN
        // Empty queue, ack and deq together: word consumed without entering the FIFO
        fq_bus.imem_ack = 1'b1;
        fq_bus.deq      = 1'b1;
        #1;
        check_eq("byp_valid", 32'(fq_bus.valid), 32'd1);
        check_eq("byp_instr", fq_bus.instr,      SALT);
        check_eq("byp_pc",    fq_bus.pc,         32'h0);
        tick();
        check_eq("byp_count", 32'(fq_bus.count), 32'd0);
        check_eq("byp_addr",  fq_bus.imem_addr,  32'h4);
        fq_bus.imem_ack = 1'b0;
        fq_bus.deq      = 1'b0;
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
